free_list: RTL and testbench

- Physical-register free list for the 2-way superscalar rename stage; sits directly upstream of the RAT.
- Supplies the new destination tags that dispatch writes into the RAT, and takes back stale tags released at retirement.
- Circular buffer with a speculative head, an architectural head and a tail; a squash restores the speculative head in one cycle.

---
 rtl/free_list_if.sv | 34 +++
 rtl/free_list.sv | 125 ++++++++++++
 tb/tb_free_list.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
`default_nettype none
//==============================================================================
// Module   : free_list_if
// Brief    : Rename-stage free-list bus: dispatch allocation and retire release.
// Revision : 1.0 - initial release
//==============================================================================
interface free_list_if #(
   parameter int NUM_OF_REQUESTS  = 2,
   parameter int NUM_OF_PREGS     = 64,
   parameter int NUM_OF_ARCH_REGS = 32
);
   localparam int c_cap  = NUM_OF_PREGS - NUM_OF_ARCH_REGS;
   localparam int c_tagw = $clog2(NUM_OF_PREGS);
   localparam int c_ptrw = $clog2(c_cap) + 1;

   logic [NUM_OF_REQUESTS-1:0]             alloc_req;
   logic [NUM_OF_REQUESTS-1:0][c_tagw-1:0] alloc_tag;
   logic                                   alloc_ready;
   logic [NUM_OF_REQUESTS-1:0]             retire_en;
   logic [NUM_OF_REQUESTS-1:0][c_tagw-1:0] retire_old_tag;
   logic                                   squash;
   logic [c_ptrw-1:0]                      free_count;

   modport master (
      output alloc_req, retire_en, retire_old_tag, squash,
      input  alloc_tag, alloc_ready, free_count
   );

   modport slave (
      input  alloc_req, retire_en, retire_old_tag, squash,
      output alloc_tag, alloc_ready, free_count
   );
endinterface
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
//==============================================================================
// Module   : free_list
// Brief    : Physical-register free list (circular buffer, speculative head,
//            architectural head, tail). Optional checks: FREE_LIST_CHECK_EN.
// Revision : 1.0 - initial release
//==============================================================================
module free_list #(
   parameter int NUM_OF_REQUESTS  = 2,
   parameter int NUM_OF_PREGS     = 64,
   parameter int NUM_OF_ARCH_REGS = 32
) (
   input  wire logic  clock,
   input  wire logic  reset,
   free_list_if.slave fl
);
   // Capacity must be a power of two so pointer low bits wrap naturally.
   localparam int c_cap  = NUM_OF_PREGS - NUM_OF_ARCH_REGS;
   localparam int c_tagw = $clog2(NUM_OF_PREGS);
   localparam int c_idxw = $clog2(c_cap);
   localparam int c_ptrw = c_idxw + 1;

   logic [c_tagw-1:0] r_entry [c_cap];
   logic [c_ptrw-1:0] r_head;
   logic [c_ptrw-1:0] r_arch_head;
   logic [c_ptrw-1:0] r_tail;

   logic [c_ptrw-1:0] w_free_count;
   logic [c_ptrw-1:0] w_alloc_cnt;
   logic [c_ptrw-1:0] w_retire_cnt;
   logic [c_ptrw-1:0] w_arch_head_next;
   logic              w_alloc_ready;
   logic [c_ptrw-1:0] w_alloc_rank  [NUM_OF_REQUESTS];
   logic [c_ptrw-1:0] w_retire_rank [NUM_OF_REQUESTS];
   logic [c_ptrw-1:0] w_rd_ptr      [NUM_OF_REQUESTS];
   logic [c_ptrw-1:0] w_wr_ptr      [NUM_OF_REQUESTS];

   // Requesting slots take consecutive entries in slot order; idle slots
   // preview the entry at their own slot offset.
   always_comb begin
      w_alloc_cnt  = '0;
      w_retire_cnt = '0;
      for (int i = 0; i < NUM_OF_REQUESTS; i++) begin
         w_alloc_rank[i]  = fl.alloc_req[i] ? w_alloc_cnt : c_ptrw'(i);
         w_retire_rank[i] = w_retire_cnt;
         w_alloc_cnt      = w_alloc_cnt + c_ptrw'(fl.alloc_req[i]);
         w_retire_cnt     = w_retire_cnt + c_ptrw'(fl.retire_en[i]);
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_OF_REQUESTS; gi++) begin : g_slot
         assign w_rd_ptr[gi]     = r_head + w_alloc_rank[gi];
         assign w_wr_ptr[gi]     = r_tail + w_retire_rank[gi];
         assign fl.alloc_tag[gi] = r_entry[w_rd_ptr[gi][c_idxw-1:0]];
      end
   endgenerate

   assign w_free_count     = r_tail - r_head;
   assign w_alloc_ready    = !fl.squash && (w_free_count >= w_alloc_cnt);
   assign w_arch_head_next = r_arch_head + w_retire_cnt;
   assign fl.alloc_ready   = w_alloc_ready;
   assign fl.free_count    = w_free_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < c_cap; k++) begin
            r_entry[k] <= c_tagw'(NUM_OF_ARCH_REGS + k);
         end
         r_head      <= '0;
         r_arch_head <= '0;
         r_tail      <= c_ptrw'(c_cap);
      end else begin
         for (int i = 0; i < NUM_OF_REQUESTS; i++) begin
            if (fl.retire_en[i]) begin
               r_entry[w_wr_ptr[i][c_idxw-1:0]] <= fl.retire_old_tag[i];
            end
         end
         r_tail      <= r_tail + w_retire_cnt;
         r_arch_head <= w_arch_head_next;
         // Squash rewinds to the post-retire architectural point.
         if (fl.squash) begin
            r_head <= w_arch_head_next;
         end else if (w_alloc_ready) begin
            r_head <= r_head + w_alloc_cnt;
         end
      end
   end

`ifdef FREE_LIST_CHECK_EN
   logic [c_ptrw-1:0] w_chk_ptr;

   always @(posedge clock) begin
      w_chk_ptr = '0;
      if (reset) begin
         if ((|fl.retire_en) && (w_free_count == c_ptrw'(c_cap))) begin
            $display("@@@ Failed");
            $finish;
         end
         if (c_ptrw'(r_tail - r_arch_head) != c_ptrw'(c_cap)) begin
            $display("@@@ Failed");
            $finish;
         end
         for (int i = 0; i < NUM_OF_REQUESTS; i++) begin
            for (int k = 0; k < c_cap; k++) begin
               w_chk_ptr = r_head + c_ptrw'(k);
               if (fl.retire_en[i] && (c_ptrw'(k) < w_free_count) &&
                   (r_entry[w_chk_ptr[c_idxw-1:0]] == fl.retire_old_tag[i])) begin
                  $display("@@@ Failed");
                  $finish;
               end
            end
         end
         if (w_alloc_cnt > c_ptrw'(NUM_OF_REQUESTS)) begin
            $display("@@@ Failed");
            $finish;
         end
      end
   end
`else
   // Checks compiled out; datapath is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
//==============================================================================
// Module   : tb_free_list
// Brief    : Self-checking bench for free_list: directed scenarios plus random
//            traffic against a queue-based free/in-flight/mapped tag model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_free_list;
   localparam int NREQ  = 2;
   localparam int NPREG = 64;
   localparam int NARCH = 32;
   localparam int CAP   = NPREG - NARCH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // Model: free tags in offer order, allocated-not-retired tags, mapped tags.
   int q_free[$];
   int q_inflight[$];
   int q_mapped[$];

   always #5 clk = ~clk;

   free_list_if #(.NUM_OF_REQUESTS(NREQ), .NUM_OF_PREGS(NPREG), .NUM_OF_ARCH_REGS(NARCH)) fl ();

   free_list #(.NUM_OF_REQUESTS(NREQ), .NUM_OF_PREGS(NPREG), .NUM_OF_ARCH_REGS(NARCH)) dut (
      .clock (clk),
      .reset (rst_n),
      .fl    (fl)
   );

   task automatic drive_idle();
      fl.alloc_req      = '0;
      fl.retire_en      = '0;
      fl.retire_old_tag = '0;
      fl.squash         = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      q_free.delete();
      q_inflight.delete();
      q_mapped.delete();
      for (int k = 0; k < CAP; k++) q_free.push_back(NARCH + k);
      for (int k = 0; k < NARCH; k++) q_mapped.push_back(k);
   endtask

   task automatic model_step(input logic [1:0] req, input logic [1:0] ren,
                             input int tag0, input int tag1, input logic sq);
      int nal;
      int t;
      nal = (!sq && q_free.size() >= $countones(req)) ? $countones(req) : 0;
      for (int k = 0; k < nal; k++) q_inflight.push_back(q_free.pop_front());
      for (int i = 0; i < 2; i++) begin
         if (ren[i]) begin
            t = q_inflight.pop_front();
            q_mapped.push_back(t);
            q_free.push_back(i == 0 ? tag0 : tag1);
         end
      end
      if (sq) begin
         for (int k = q_inflight.size() - 1; k >= 0; k--) q_free.push_front(q_inflight[k]);
         q_inflight.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (fl.free_count !== 6'd32) begin bad++; $display("FAIL reset_free_count got=%0d want=32", fl.free_count); end
      total++; if (fl.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", fl.alloc_ready); end
      total++; if (fl.alloc_tag[0] !== 6'd32) begin bad++; $display("FAIL reset_tag0 got=%0d want=32", fl.alloc_tag[0]); end
      total++; if (fl.alloc_tag[1] !== 6'd33) begin bad++; $display("FAIL reset_tag1 got=%0d want=33", fl.alloc_tag[1]); end
   endtask

   task automatic test_basic_alloc();
      do_reset();
      fl.alloc_req = 2'b11;
      #1;
      total++; if (fl.alloc_tag[0] !== 6'd32 || fl.alloc_tag[1] !== 6'd33) begin bad++; $display("FAIL alloc2_tags got=%0d,%0d want=32,33", fl.alloc_tag[0], fl.alloc_tag[1]); end
      @(negedge clk);
      fl.alloc_req = 2'b00;
      #1;
      total++; if (fl.alloc_tag[0] !== 6'd34 || fl.alloc_tag[1] !== 6'd35) begin bad++; $display("FAIL after_alloc2_tags got=%0d,%0d want=34,35", fl.alloc_tag[0], fl.alloc_tag[1]); end
      total++; if (fl.free_count !== 6'd30) begin bad++; $display("FAIL after_alloc2_count got=%0d want=30", fl.free_count); end
      fl.alloc_req = 2'b01;
      @(negedge clk);
      fl.alloc_req = 2'b10;
      #1;
      total++; if (fl.free_count !== 6'd29) begin bad++; $display("FAIL alloc1_count got=%0d want=29", fl.free_count); end
      total++; if (fl.alloc_tag[1] !== 6'd35) begin bad++; $display("FAIL slot1_only_tag got=%0d want=35", fl.alloc_tag[1]); end
      drive_idle();
   endtask

   task automatic test_empty_wrap();
      do_reset();
      fl.alloc_req = 2'b11;
      repeat (16) @(negedge clk);
      fl.alloc_req = 2'b00;
      #1;
      total++; if (fl.free_count !== 6'd0) begin bad++; $display("FAIL empty_count got=%0d want=0", fl.free_count); end
      total++; if (fl.alloc_ready !== 1'b1) begin bad++; $display("FAIL empty_noreq_ready got=%b want=1", fl.alloc_ready); end
      fl.alloc_req = 2'b01;
      #1;
      total++; if (fl.alloc_ready !== 1'b0) begin bad++; $display("FAIL empty_ready got=%b want=0", fl.alloc_ready); end
      @(negedge clk);
      fl.alloc_req         = 2'b00;
      fl.retire_en         = 2'b11;
      fl.retire_old_tag[0] = 6'd5;
      fl.retire_old_tag[1] = 6'd7;
      #1;
      total++; if (fl.free_count !== 6'd0) begin bad++; $display("FAIL no_bypass_count got=%0d want=0", fl.free_count); end
      @(negedge clk);
      drive_idle();
      #1;
      total++; if (fl.free_count !== 6'd2) begin bad++; $display("FAIL wrap_count got=%0d want=2", fl.free_count); end
      total++; if (fl.alloc_tag[0] !== 6'd5 || fl.alloc_tag[1] !== 6'd7) begin bad++; $display("FAIL wrap_tags got=%0d,%0d want=5,7", fl.alloc_tag[0], fl.alloc_tag[1]); end
   endtask

   task automatic test_squash();
      do_reset();
      fl.alloc_req = 2'b11;
      @(negedge clk);
      fl.alloc_req = 2'b01;
      @(negedge clk);
      fl.alloc_req = 2'b11;
      fl.squash    = 1'b1;
      #1;
      total++; if (fl.alloc_ready !== 1'b0) begin bad++; $display("FAIL squash_ready got=%b want=0", fl.alloc_ready); end
      total++; if (fl.free_count !== 6'd29) begin bad++; $display("FAIL pre_squash_count got=%0d want=29", fl.free_count); end
      @(negedge clk);
      drive_idle();
      #1;
      total++; if (fl.free_count !== 6'd32) begin bad++; $display("FAIL post_squash_count got=%0d want=32", fl.free_count); end
      total++; if (fl.alloc_tag[0] !== 6'd32) begin bad++; $display("FAIL post_squash_tag0 got=%0d want=32", fl.alloc_tag[0]); end
   endtask

   task automatic test_squash_retire();
      do_reset();
      fl.alloc_req = 2'b11;
      @(negedge clk);
      drive_idle();
      fl.squash            = 1'b1;
      fl.retire_en         = 2'b01;
      fl.retire_old_tag[0] = 6'd12;
      @(negedge clk);
      drive_idle();
      #1;
      total++; if (fl.free_count !== 6'd32) begin bad++; $display("FAIL sq_ret_count got=%0d want=32", fl.free_count); end
      total++; if (fl.alloc_tag[0] !== 6'd33) begin bad++; $display("FAIL sq_ret_tag0 got=%0d want=33", fl.alloc_tag[0]); end
      fl.alloc_req = 2'b11;
      repeat (15) @(negedge clk);
      fl.alloc_req = 2'b01;
      @(negedge clk);
      fl.alloc_req = 2'b01;
      #1;
      total++; if (fl.free_count !== 6'd1) begin bad++; $display("FAIL last_entry_count got=%0d want=1", fl.free_count); end
      total++; if (fl.alloc_tag[0] !== 6'd12) begin bad++; $display("FAIL last_entry_tag got=%0d want=12", fl.alloc_tag[0]); end
      drive_idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      fl.alloc_req = 2'b11;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (fl.free_count !== 6'd32) begin bad++; $display("FAIL async_rst_count got=%0d want=32", fl.free_count); end
      total++; if (fl.alloc_tag[0] !== 6'd32 || fl.alloc_tag[1] !== 6'd33) begin bad++; $display("FAIL async_rst_tags got=%0d,%0d want=32,33", fl.alloc_tag[0], fl.alloc_tag[1]); end
      total++; if (fl.alloc_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready got=%b want=1", fl.alloc_ready); end
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [1:0] req;
      logic [1:0] ren;
      logic       sq;
      int         nret;
      int         tg [2];
      int         j;
      int         lim;
      bit         exp_ready;
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         req  = 2'($urandom_range(0, 3));
         sq   = ($urandom_range(0, 19) == 0);
         lim  = (q_inflight.size() < 2) ? q_inflight.size() : 2;
         nret = $urandom_range(0, lim);
         if (cyc < 300 && $urandom_range(0, 2) != 0) nret = 0;
         ren  = (nret == 2) ? 2'b11 : (nret == 1) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10) : 2'b00;
         tg[0] = 0;
         tg[1] = 0;
         for (int i = 0; i < 2; i++) if (ren[i]) tg[i] = q_mapped.pop_front();
         fl.alloc_req         = req;
         fl.retire_en         = ren;
         fl.retire_old_tag[0] = 6'(tg[0]);
         fl.retire_old_tag[1] = 6'(tg[1]);
         fl.squash            = sq;
         #1;
         exp_ready = !sq && (q_free.size() >= $countones(req));
         total++; if (fl.free_count !== 6'(q_free.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, fl.free_count, q_free.size()); end
         total++; if (fl.alloc_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, fl.alloc_ready, exp_ready); end
         j = 0;
         for (int i = 0; i < 2; i++) begin
            if (exp_ready && req[i]) begin
               total++; if (fl.alloc_tag[i] !== 6'(q_free[j])) begin bad++; $display("FAIL rnd_tag cyc=%0d slot=%0d got=%0d want=%0d", cyc, i, fl.alloc_tag[i], q_free[j]); end
               j++;
            end else if (req == 2'b00 && q_free.size() > i) begin
               total++; if (fl.alloc_tag[i] !== 6'(q_free[i])) begin bad++; $display("FAIL rnd_idle_tag cyc=%0d slot=%0d got=%0d want=%0d", cyc, i, fl.alloc_tag[i], q_free[i]); end
            end
         end
         @(negedge clk);
         model_step(req, ren, tg[0], tg[1], sq);
      end
      drive_idle();
      #1;
      total++; if (fl.free_count !== 6'(q_free.size())) begin bad++; $display("FAIL rnd_final_count got=%0d want=%0d", fl.free_count, q_free.size()); end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_basic_alloc();
      test_empty_wrap();
      test_squash();
      test_squash_retire();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
